// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing generator: pixel-enable divider, free-running
// column/line counters, registered sync pulses, visible-area flag and frame pulse.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_bright;
    logic             r_frame_start;

    logic             w_div_last;
    logic             w_h_last;
    logic             w_v_last;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic [10:0]      w_h_ext;
    logic [10:0]      w_v_ext;

    assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_h_last   = (r_h == 10'(H_TOTAL - 1));
    assign w_v_last   = (r_v == 10'(V_TOTAL - 1));

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (r_pix_en) begin
            if (w_h_last) begin
                w_h_nxt = '0;
                w_v_nxt = w_v_last ? 10'd0 : r_v + 10'd1;
            end else begin
                w_h_nxt = r_h + 10'd1;
            end
        end
    end

    // 11-bit compares so a visible-end bound equal to 1024 still works.
    assign w_h_ext = {1'b0, w_h_nxt};
    assign w_v_ext = {1'b0, w_v_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_last ? '0 : r_div + DIV_W'(1);
            r_pix_en <= w_div_last;
        end
    end

    // Sync and bright derive from the next position, so they never lag the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_bright      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= (w_h_ext >= 11'(H_SYNC));
            r_vsync       <= (w_v_ext >= 11'(V_SYNC));
            r_bright      <= (w_h_ext >= 11'(H_VIS_START)) && (w_h_ext < 11'(H_VIS_END)) &&
                             (w_v_ext >= 11'(V_VIS_START)) && (w_v_ext < 11'(V_VIS_END));
            r_frame_start <= r_pix_en && (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
        end
    end

    assign pix_en      = r_pix_en;
    assign hCount      = r_h;
    assign vCount      = r_v;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign bright      = r_bright;
    assign frame_start = r_frame_start;

endmodule
